// File: rtl/counter_event_issuer_if.sv
// Bundle between event sources and the counter-event issuer: request pulses and stall in,
// registered incr/decr issue strobes, drop pulses and busy out.
interface counter_event_issuer_if #(
    parameter int NUM_CH = 8,
    parameter int ADDR_W = 3
);
    logic [NUM_CH-1:0] inc_req;
    logic [NUM_CH-1:0] dec_req;
    logic              stall;
    logic              incr;
    logic [ADDR_W-1:0] incr_addr;
    logic              decr;
    logic [ADDR_W-1:0] decr_addr;
    logic              inc_drop;
    logic              dec_drop;
    logic              busy;

    modport master (
        input  inc_req, dec_req, stall,
        output incr, incr_addr, decr, decr_addr, inc_drop, dec_drop, busy
    );

    modport slave (
        output inc_req, dec_req, stall,
        input  incr, incr_addr, decr, decr_addr, inc_drop, dec_drop, busy
    );
endinterface

// File: rtl/counter_event_issuer.sv
// Per-channel pending counters feeding two independent round-robin issuers (incr/decr).
// Optional macro NET_CANCEL_EN: channels with both directions pending cancel locally.
module counter_event_issuer #(
    parameter int NUM_CH = 8,
    parameter int ADDR_W = 3,
    parameter int PEND_W = 4
) (
    input logic                    clk,
    input logic                    rst,
    counter_event_issuer_if.master bus
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [ADDR_W:0]   NUM_CH_W = (ADDR_W+1)'(NUM_CH);

    logic [PEND_W-1:0] inc_pend_q [NUM_CH];
    logic [PEND_W-1:0] inc_pend_d [NUM_CH];
    logic [PEND_W-1:0] dec_pend_q [NUM_CH];
    logic [PEND_W-1:0] dec_pend_d [NUM_CH];

    logic [ADDR_W-1:0] inc_ptr_q, inc_ptr_d;
    logic [ADDR_W-1:0] dec_ptr_q, dec_ptr_d;
    logic              incr_q, incr_d;
    logic [ADDR_W-1:0] incr_addr_q, incr_addr_d;
    logic              decr_q, decr_d;
    logic [ADDR_W-1:0] decr_addr_q, decr_addr_d;
    logic              inc_drop_q, inc_drop_d;
    logic              dec_drop_q, dec_drop_d;

    logic [NUM_CH-1:0] inc_cand, dec_cand, cancel;
    logic [NUM_CH-1:0] inc_issue, dec_issue;
    logic [NUM_CH-1:0] inc_sat, dec_sat;
    logic [NUM_CH-1:0] any_pend;
    logic [ADDR_W:0]   inc_pick, dec_pick;
    logic              inc_found, dec_found;
    logic [ADDR_W-1:0] inc_sel, dec_sel;

    // First set bit of cand at or after ptr, wrapping; result is {found, index}.
    function automatic logic [ADDR_W:0] rr_pick(input logic [NUM_CH-1:0] cand,
                                                input logic [ADDR_W-1:0] ptr);
        logic            found;
        logic [ADDR_W-1:0] sel;
        logic [ADDR_W:0]   idx;
        found = 1'b0;
        sel   = ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = {1'b0, ptr} + (ADDR_W+1)'(k);
            if (idx >= NUM_CH_W) begin
                idx = idx - NUM_CH_W;
            end
            if (!found && cand[idx[ADDR_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[ADDR_W-1:0];
            end
        end
        return {found, sel};
    endfunction

    // Saturating pending update; result is {saturated_drop, next_value}.
    function automatic logic [PEND_W:0] pend_next(input logic [PEND_W-1:0] pend,
                                                  input logic req,
                                                  input logic take);
        logic [PEND_W-1:0] nxt;
        logic              sat;
        nxt = pend;
        sat = 1'b0;
        if (req && !take) begin
            if (pend == PEND_MAX) begin
                sat = 1'b1;
            end else begin
                nxt = pend + PEND_W'(1);
            end
        end else if (!req && take) begin
            nxt = pend - PEND_W'(1);
        end
        return {sat, nxt};
    endfunction

    always_comb begin
        inc_cand = '0;
        dec_cand = '0;
        cancel   = '0;
        any_pend = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            logic has_inc;
            logic has_dec;
            has_inc     = (inc_pend_q[i] != '0);
            has_dec     = (dec_pend_q[i] != '0);
            any_pend[i] = has_inc || has_dec;
`ifdef NET_CANCEL_EN
            // Opposing events on one channel annihilate instead of being issued.
            cancel[i]   = has_inc && has_dec;
            inc_cand[i] = has_inc && !(has_inc && has_dec);
            dec_cand[i] = has_dec && !(has_inc && has_dec);
`else
            inc_cand[i] = has_inc;
            dec_cand[i] = has_dec;
`endif
        end
    end

    always_comb begin
        inc_pick  = rr_pick(inc_cand, inc_ptr_q);
        dec_pick  = rr_pick(dec_cand, dec_ptr_q);
        inc_found = inc_pick[ADDR_W];
        inc_sel   = inc_pick[ADDR_W-1:0];
        dec_found = dec_pick[ADDR_W];
        dec_sel   = dec_pick[ADDR_W-1:0];
    end

    always_comb begin
        incr_d      = 1'b0;
        incr_addr_d = incr_addr_q;
        inc_ptr_d   = inc_ptr_q;
        inc_issue   = '0;
        decr_d      = 1'b0;
        decr_addr_d = decr_addr_q;
        dec_ptr_d   = dec_ptr_q;
        dec_issue   = '0;
        if (!bus.stall && inc_found) begin
            incr_d             = 1'b1;
            incr_addr_d        = inc_sel;
            inc_issue[inc_sel] = 1'b1;
            inc_ptr_d          = (inc_sel == ADDR_W'(NUM_CH - 1)) ? '0 : inc_sel + ADDR_W'(1);
        end
        if (!bus.stall && dec_found) begin
            decr_d             = 1'b1;
            decr_addr_d        = dec_sel;
            dec_issue[dec_sel] = 1'b1;
            dec_ptr_d          = (dec_sel == ADDR_W'(NUM_CH - 1)) ? '0 : dec_sel + ADDR_W'(1);
        end
    end

    always_comb begin
        inc_sat = '0;
        dec_sat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            logic [PEND_W:0] inc_res;
            logic [PEND_W:0] dec_res;
            inc_res       = pend_next(inc_pend_q[i], bus.inc_req[i], inc_issue[i] || cancel[i]);
            dec_res       = pend_next(dec_pend_q[i], bus.dec_req[i], dec_issue[i] || cancel[i]);
            inc_pend_d[i] = inc_res[PEND_W-1:0];
            inc_sat[i]    = inc_res[PEND_W];
            dec_pend_d[i] = dec_res[PEND_W-1:0];
            dec_sat[i]    = dec_res[PEND_W];
        end
        inc_drop_d = |inc_sat;
        dec_drop_d = |dec_sat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                inc_pend_q[i] <= '0;
                dec_pend_q[i] <= '0;
            end
            inc_ptr_q   <= '0;
            dec_ptr_q   <= '0;
            incr_q      <= 1'b0;
            incr_addr_q <= '0;
            decr_q      <= 1'b0;
            decr_addr_q <= '0;
            inc_drop_q  <= 1'b0;
            dec_drop_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                inc_pend_q[i] <= inc_pend_d[i];
                dec_pend_q[i] <= dec_pend_d[i];
            end
            inc_ptr_q   <= inc_ptr_d;
            dec_ptr_q   <= dec_ptr_d;
            incr_q      <= incr_d;
            incr_addr_q <= incr_addr_d;
            decr_q      <= decr_d;
            decr_addr_q <= decr_addr_d;
            inc_drop_q  <= inc_drop_d;
            dec_drop_q  <= dec_drop_d;
        end
    end

    assign bus.incr      = incr_q;
    assign bus.incr_addr = incr_addr_q;
    assign bus.decr      = decr_q;
    assign bus.decr_addr = decr_addr_q;
    assign bus.inc_drop  = inc_drop_q;
    assign bus.dec_drop  = dec_drop_q;
    assign bus.busy      = (|any_pend) || incr_q || decr_q;

endmodule

// File: tb/tb_counter_event_issuer.sv
// Bench for counter_event_issuer: vector table, directed corner sequences and
// randomized traffic against an event-count reference model (honours NET_CANCEL_EN).
module tb_counter_event_issuer;

    localparam int NUM_CH = 8;
    localparam int ADDR_W = 3;
    localparam int PEND_W = 4;
    localparam int PMAX   = (1 << PEND_W) - 1;
`ifdef NET_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    counter_event_issuer_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

    counter_event_issuer #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .PEND_W(PEND_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: outstanding event counts and arbitration pointers.
    int m_inc [NUM_CH];
    int m_dec [NUM_CH];
    int m_iptr, m_dptr;
    int e_iaddr, e_daddr;
    bit e_incr, e_decr, e_idrop, e_ddrop, e_busy;

    typedef struct {
        logic [7:0] inc;
        logic [7:0] dec;
        logic       stall;
        logic       e_incr;
        logic [2:0] e_iaddr;
        logic       e_decr;
        logic [2:0] e_daddr;
        logic       e_busy;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_inc[c] = 0;
            m_dec[c] = 0;
        end
        m_iptr = 0; m_dptr = 0; e_iaddr = 0; e_daddr = 0;
        e_incr = 0; e_decr = 0; e_idrop = 0; e_ddrop = 0; e_busy = 0;
    endtask

    task automatic model_step(input logic [7:0] ireq, input logic [7:0] dreq, input logic stl);
        int iss_i [NUM_CH];
        int iss_d [NUM_CH];
        int can   [NUM_CH];
        int c, n;
        for (int k = 0; k < NUM_CH; k++) begin
            iss_i[k] = 0;
            iss_d[k] = 0;
            can[k]   = (CANCEL && m_inc[k] > 0 && m_dec[k] > 0) ? 1 : 0;
        end
        e_incr = 0;
        e_decr = 0;
        if (!stl) begin
            for (int k = 0; k < NUM_CH; k++) begin
                c = (m_iptr + k) % NUM_CH;
                if (!e_incr && m_inc[c] > 0 && can[c] == 0) begin
                    e_incr = 1; e_iaddr = c; iss_i[c] = 1;
                end
            end
            for (int k = 0; k < NUM_CH; k++) begin
                c = (m_dptr + k) % NUM_CH;
                if (!e_decr && m_dec[c] > 0 && can[c] == 0) begin
                    e_decr = 1; e_daddr = c; iss_d[c] = 1;
                end
            end
            if (e_incr) m_iptr = (e_iaddr + 1) % NUM_CH;
            if (e_decr) m_dptr = (e_daddr + 1) % NUM_CH;
        end
        e_idrop = 0;
        e_ddrop = 0;
        e_busy  = e_incr || e_decr;
        for (int k = 0; k < NUM_CH; k++) begin
            n = m_inc[k] + int'(ireq[k]) - iss_i[k] - can[k];
            if (n > PMAX) begin n = PMAX; e_idrop = 1; end
            m_inc[k] = n;
            n = m_dec[k] + int'(dreq[k]) - iss_d[k] - can[k];
            if (n > PMAX) begin n = PMAX; e_ddrop = 1; end
            m_dec[k] = n;
            if (m_inc[k] != 0 || m_dec[k] != 0) e_busy = 1;
        end
    endtask

    task automatic check_output();
        check("incr",      32'(bus.incr),      32'(e_incr));
        check("incr_addr", 32'(bus.incr_addr), 32'(e_iaddr));
        check("decr",      32'(bus.decr),      32'(e_decr));
        check("decr_addr", 32'(bus.decr_addr), 32'(e_daddr));
        check("inc_drop",  32'(bus.inc_drop),  32'(e_idrop));
        check("dec_drop",  32'(bus.dec_drop),  32'(e_ddrop));
        check("busy",      32'(bus.busy),      32'(e_busy));
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic apply_stimulus(input logic [7:0] ireq, input logic [7:0] dreq, input logic stl);
        bus.inc_req = ireq;
        bus.dec_req = dreq;
        bus.stall   = stl;
        model_step(ireq, dreq, stl);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic do_reset();
        bus.inc_req = '0;
        bus.dec_req = '0;
        bus.stall   = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check("reset_incr", 32'(bus.incr), 32'd0);
        check("reset_decr", 32'(bus.decr), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_output();
        rst = 1'b1;
    endtask

    initial begin
        int strobes, drops, waited;
        logic [7:0] ri, rd;
        logic rs;

        vecs[0] = '{8'h04, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1};
        vecs[1] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0};
        vecs[3] = '{8'h02, 8'h02, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0, 1'b1};
`ifdef NET_CANCEL_EN
        vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0};
`else
        vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1, 3'd1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 3'd1, 1'b0};
`endif

        // Reset then idle.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(8'h00, 8'h00, 1'b0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end

        // Single event and opposing events, table-driven.
        for (int v = 0; v < 6; v++) begin
            apply_stimulus(vecs[v].inc, vecs[v].dec, vecs[v].stall);
            check("vec_incr",      32'(bus.incr),      32'(vecs[v].e_incr));
            check("vec_incr_addr", 32'(bus.incr_addr), 32'(vecs[v].e_iaddr));
            check("vec_decr",      32'(bus.decr),      32'(vecs[v].e_decr));
            check("vec_decr_addr", 32'(bus.decr_addr), 32'(vecs[v].e_daddr));
            check("vec_busy",      32'(bus.busy),      32'(vecs[v].e_busy));
        end

        // Contention: all channels at once drain in index order, then 0x81 wraps.
        do_reset();
        apply_stimulus(8'hFF, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(8'h00, 8'h00, 1'b0);
            check("rr_incr", 32'(bus.incr), 32'd1);
            check("rr_addr", 32'(bus.incr_addr), 32'(k));
        end
        apply_stimulus(8'h81, 8'h00, 1'b0);
        apply_stimulus(8'h00, 8'h00, 1'b0);
        check("wrap_first",  32'(bus.incr_addr), 32'd0);
        apply_stimulus(8'h00, 8'h00, 1'b0);
        check("wrap_second", 32'(bus.incr_addr), 32'd7);

        // Saturation under stall.
        do_reset();
        drops = 0;
        for (int k = 0; k < 17; k++) begin
            apply_stimulus(8'h01, 8'h00, 1'b1);
            if (bus.inc_drop) drops++;
        end
        check("sat_drops", 32'(drops), 32'd2);
        strobes = 0;
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(8'h00, 8'h00, 1'b0);
            if (bus.incr && bus.incr_addr == 3'd0) strobes++;
        end
        check("sat_strobes", 32'(strobes), 32'd15);

        // Stall mid-stream on the decrement side.
        do_reset();
        apply_stimulus(8'h00, 8'h30, 1'b0);
        waited = 0;
        apply_stimulus(8'h00, 8'h00, 1'b0);
        while (!bus.decr && waited < 10) begin
            apply_stimulus(8'h00, 8'h00, 1'b0);
            waited++;
        end
        check("stall_first_addr", 32'(bus.decr_addr), 32'd4);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(8'h00, 8'h00, 1'b1);
            check("stall_gap", 32'(bus.decr), 32'd0);
        end
        apply_stimulus(8'h00, 8'h00, 1'b0);
        check("stall_resume",      32'(bus.decr),      32'd1);
        check("stall_resume_addr", 32'(bus.decr_addr), 32'd5);

        // Reset in the middle of a burst.
        do_reset();
        apply_stimulus(8'hFF, 8'h00, 1'b0);
        strobes = 0;
        waited  = 0;
        while (strobes < 3 && waited < 10) begin
            apply_stimulus(8'h00, 8'h00, 1'b0);
            if (bus.incr) strobes++;
            waited++;
        end
        check("midrst_seen", 32'(strobes), 32'd3);
        do_reset();
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(8'h00, 8'h00, 1'b0);
            if (bus.incr) strobes++;
        end
        check("midrst_after", 32'(strobes), 32'd0);

        // Randomized traffic with occasional stall bursts.
        do_reset();
        for (int k = 0; k < 500; k++) begin
            ri = 8'($urandom) & 8'($urandom);
            rd = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 15) == 0) ri = 8'hFF;
            rs = ((k % 100) >= 70) || ($urandom_range(0, 5) == 0);
            apply_stimulus(ri, rd, rs);
        end
        for (int k = 0; k < 300; k++) begin
            apply_stimulus(8'h00, 8'h00, 1'b0);
        end
        check("drain_busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
